// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA framebuffer fetch controller:
//   - state_t          : fetch FSM states (IDLE, CREDIT, ISSUE)
//   - BURST_BEATS_DEF  : default beats per read burst
//   - BEAT_BYTES_DEF   : default bytes per beat
// ---------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  localparam int unsigned BURST_BEATS_DEF = 16;
  localparam int unsigned BEAT_BYTES_DEF  = 4;

endpackage

// File: rtl/vga_fb_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_fb_fetch_ctrl_if
// Burst read command channel between the fetch controller (master) and the
// framebuffer read master m_axi_fb (slave).
//   cmd_valid : master -> slave, a command is offered
//   cmd_addr  : master -> slave, burst start byte address
//   cmd_ready : slave -> master, command can be taken
//
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. Once cmd_valid is raised, cmd_valid and cmd_addr
// hold steady until that transfer; the master never withdraws an offer, and
// cmd_ready may be driven independently of cmd_valid.
// ---------------------------------------------------------------------------
interface vga_fb_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;

  modport master (
    output cmd_valid,
    output cmd_addr,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    output cmd_ready
  );
endinterface

// File: rtl/vga_fb_credit.sv
// ---------------------------------------------------------------------------
// vga_fb_credit
// Tracks beats that have been requested but not yet written into the line
// FIFO, and says whether the FIFO has room for one more full burst.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_fifo_free   : free beats in the line FIFO
//   i_issue       : a burst command was accepted this cycle
//   i_beat        : one beat was written into the FIFO this cycle
//   o_credit_ok   : (fifo_free - outstanding) >= BURST_BEATS, negative -> 0
// ---------------------------------------------------------------------------
module vga_fb_credit #(
  parameter int BURST_BEATS = 16,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(FIFO_DEPTH):0]  i_fifo_free,
  input  logic                         i_issue,
  input  logic                         i_beat,
  output logic                         o_credit_ok
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BB    = CW'(BURST_BEATS);
  localparam logic [CW-1:0] BB_M1 = CW'(BURST_BEATS - 1);

  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_avail;

  // Clamp at zero: more in flight than free space means no credit at all.
  always_comb begin
    w_avail = '0;
    if (i_fifo_free > r_outstanding) w_avail = i_fifo_free - r_outstanding;
  end

  assign o_credit_ok = (w_avail >= BB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else if (i_issue) begin
      // A beat landing in the same cycle as a new burst nets BURST_BEATS-1.
      r_outstanding <= r_outstanding + (i_beat ? BB_M1 : BB);
    end else if (i_beat && (r_outstanding != '0)) begin
      // Stray beats with nothing outstanding are dropped, never underflow.
      r_outstanding <= r_outstanding - CW'(1);
    end
  end

endmodule

// File: rtl/vga_fb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// vga_fb_fetch_ctrl
// Walks a framebuffer line by line, issuing fixed-size burst read commands
// whenever the line FIFO has room for a whole burst.
//   ACLK, ARESETN        : clock, asynchronous active-low reset
//   cfg_enable           : fetch enable (low aborts after any pending offer)
//   cfg_base_addr        : frame base byte address
//   cfg_stride           : byte distance between line starts
//   cfg_lines            : lines per frame
//   cfg_bursts_per_line  : bursts per line
//   frame_start          : one-cycle pulse starting a frame
//   fifo_free            : free beats in the line FIFO
//   beat_in              : one beat written into the line FIFO
//   m_axi_fb             : burst command channel (master side)
//   busy                 : frame fetch in progress
//   frame_done           : one-cycle pulse after the last command of a frame
//   err_overrun          : sticky, frame_start seen while busy
//   err_clr              : clears err_overrun (a same-cycle set wins)
//   dbg_state            : current FSM state
// ---------------------------------------------------------------------------
module vga_fb_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BURST_BEATS = BURST_BEATS_DEF,
  parameter int BEAT_BYTES  = BEAT_BYTES_DEF,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        cfg_enable,
  input  logic [ADDR_W-1:0]           cfg_base_addr,
  input  logic [15:0]                 cfg_stride,
  input  logic [11:0]                 cfg_lines,
  input  logic [7:0]                  cfg_bursts_per_line,
  input  logic                        frame_start,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_free,
  input  logic                        beat_in,
  vga_fb_fetch_ctrl_if.master         m_axi_fb,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        err_overrun,
  input  logic                        err_clr,
  output state_t                      dbg_state
);

  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_BEATS * BEAT_BYTES);

  state_t            r_state;
  logic              r_cmd_valid;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [ADDR_W-1:0] r_line_addr;
  logic [15:0]       r_stride;
  logic [11:0]       r_lines;
  logic [7:0]        r_bursts;
  logic [11:0]       r_line;
  logic [7:0]        r_burst;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_err_overrun;

  logic              w_hs;
  logic              w_credit_ok;
  logic              w_last_burst;
  logic              w_last_line;
  logic [ADDR_W-1:0] w_next_line_addr;

  // r_cmd_valid is only ever high in ISSUE, so this is the accepted command.
  assign w_hs             = r_cmd_valid & m_axi_fb.cmd_ready;
  assign w_last_burst     = (r_burst == (r_bursts - 8'd1));
  assign w_last_line      = (r_line == (r_lines - 12'd1));
  assign w_next_line_addr = r_line_addr + ADDR_W'(r_stride);

  vga_fb_credit #(
    .BURST_BEATS (BURST_BEATS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_credit (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .i_fifo_free (fifo_free),
    .i_issue     (w_hs),
    .i_beat      (beat_in),
    .o_credit_ok (w_credit_ok)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= IDLE;
      r_cmd_valid   <= 1'b0;
      r_cmd_addr    <= '0;
      r_line_addr   <= '0;
      r_stride      <= '0;
      r_lines       <= '0;
      r_bursts      <= '0;
      r_line        <= '0;
      r_burst       <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      // Set has priority over clear.
      if (frame_start && r_busy)  r_err_overrun <= 1'b1;
      else if (err_clr)           r_err_overrun <= 1'b0;

      case (r_state)
        IDLE: begin
          if (frame_start && cfg_enable) begin
            if ((cfg_lines == 12'd0) || (cfg_bursts_per_line == 8'd0)) begin
              // Empty frame: report completion without touching the bus.
              r_frame_done <= 1'b1;
            end else begin
              // Snapshot config so mid-frame writes cannot disturb the walk.
              r_stride    <= cfg_stride;
              r_lines     <= cfg_lines;
              r_bursts    <= cfg_bursts_per_line;
              r_line_addr <= cfg_base_addr;
              r_cmd_addr  <= cfg_base_addr;
              r_line      <= '0;
              r_burst     <= '0;
              r_busy      <= 1'b1;
              r_state     <= CREDIT;
            end
          end
        end

        CREDIT: begin
          if (!cfg_enable) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_credit_ok) begin
            r_cmd_valid <= 1'b1;
            r_state     <= ISSUE;
          end
        end

        ISSUE: begin
          // The offer stays up regardless of cfg_enable until it is taken.
          if (w_hs) begin
            r_cmd_valid <= 1'b0;
            if (w_last_burst && w_last_line) begin
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= IDLE;
            end else begin
              if (w_last_burst) begin
                r_burst     <= '0;
                r_line      <= r_line + 12'd1;
                r_line_addr <= w_next_line_addr;
                r_cmd_addr  <= w_next_line_addr;
              end else begin
                r_burst    <= r_burst + 8'd1;
                r_cmd_addr <= r_cmd_addr + BURST_BYTES;
              end
              if (cfg_enable) begin
                r_state <= CREDIT;
              end else begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end
          end
        end

        default: begin
          r_cmd_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign m_axi_fb.cmd_valid = r_cmd_valid;
  assign m_axi_fb.cmd_addr  = r_cmd_addr;
  assign busy               = r_busy;
  assign frame_done         = r_frame_done;
  assign err_overrun        = r_err_overrun;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_vga_fb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_fetch_ctrl
// Directed bench for vga_fb_fetch_ctrl. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
// Expected command addresses live in exp_q as {last_of_frame, addr}.
// ---------------------------------------------------------------------------
module tb_vga_fb_fetch_ctrl;
  import vga_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic [15:0] cfg_stride = '0;
  logic [11:0] cfg_lines = '0;
  logic [7:0]  cfg_bursts_per_line = '0;
  logic        frame_start = 1'b0;
  logic [9:0]  fifo_free = '0;
  logic        beat_in = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        err_overrun;
  state_t      dbg_state;

  vga_fb_fetch_ctrl_if #(.ADDR_W(32)) fb_if ();

  vga_fb_fetch_ctrl #(
    .ADDR_W      (32),
    .BURST_BEATS (16),
    .BEAT_BYTES  (4),
    .FIFO_DEPTH  (512)
  ) dut (
    .ACLK                (ACLK),
    .ARESETN             (ARESETN),
    .cfg_enable          (cfg_enable),
    .cfg_base_addr       (cfg_base_addr),
    .cfg_stride          (cfg_stride),
    .cfg_lines           (cfg_lines),
    .cfg_bursts_per_line (cfg_bursts_per_line),
    .frame_start         (frame_start),
    .fifo_free           (fifo_free),
    .beat_in             (beat_in),
    .m_axi_fb            (fb_if),
    .busy                (busy),
    .frame_done          (frame_done),
    .err_overrun         (err_overrun),
    .err_clr             (err_clr),
    .dbg_state           (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    ARESETN          = 1'b0;
    fb_if.cmd_ready  = 1'b0;
    frame_start      = 1'b0;
    beat_in          = 1'b0;
    err_clr          = 1'b0;
    repeat (2) tick();
    ARESETN = 1'b1;
    tick();
  endtask

  task automatic set_cfg(input logic [31:0] base, input logic [15:0] stride,
                         input logic [11:0] lines, input logic [7:0] bursts);
    cfg_enable          = 1'b1;
    cfg_base_addr       = base;
    cfg_stride          = stride;
    cfg_lines           = lines;
    cfg_bursts_per_line = bursts;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic push(input logic [31:0] addr, input logic last);
    exp_q.push_back({last, addr});
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat_in = 1'b1;
      tick();
    end
    beat_in = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int cyc = 0;
    while (!fb_if.cmd_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    check("wait_valid", fb_if.cmd_valid, 1);
  endtask

  // Consume n accepted commands, comparing address and the frame_done pulse
  // that must follow exactly the last command of a frame.
  task automatic take_cmds(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    logic [32:0] e;
    while (got < n && cyc < budget) begin
      if (fb_if.cmd_valid && fb_if.cmd_ready) begin
        if (exp_q.size() == 0) begin
          check("exp_q_size", exp_q.size(), 1);
          tick();
        end else begin
          e = exp_q.pop_front();
          check("cmd_addr", fb_if.cmd_addr, e[31:0]);
          tick();
          check("frame_done", frame_done, e[32]);
        end
        got++;
      end else begin
        tick();
      end
      cyc++;
    end
    check("cmd_count", got, n);
  endtask

  // ---------------- tests ----------------
  initial begin
    fb_if.cmd_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_valid", fb_if.cmd_valid, 0);
    check("rst_addr", fb_if.cmd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err_overrun, 0);
    check("rst_state", dbg_state, IDLE);
    do_reset();

    // Two lines of three bursts
    set_cfg(32'h1000_0000, 16'h0500, 12'd2, 8'd3);
    fifo_free = 10'd512;
    fb_if.cmd_ready = 1'b1;
    push(32'h1000_0000, 0); push(32'h1000_0040, 0); push(32'h1000_0080, 0);
    push(32'h1000_0500, 0); push(32'h1000_0540, 0); push(32'h1000_0580, 1);
    start_frame();
    check("t2_busy", busy, 1);
    check("t2_state", dbg_state, CREDIT);
    take_cmds(6, 100);
    check("t2_busy_end", busy, 0);
    check("t2_state_end", dbg_state, IDLE);
    tick();
    check("t2_fd_single", frame_done, 0);

    // Credit gating and outstanding accounting
    do_reset();
    set_cfg(32'h0000_2000, 16'h0100, 12'd1, 8'd2);
    fifo_free = 10'd20;
    fb_if.cmd_ready = 1'b1;
    push(32'h0000_2000, 0);
    start_frame();
    take_cmds(1, 50);
    repeat (20) tick();
    check("t3_hold_valid", fb_if.cmd_valid, 0);
    check("t3_hold_state", dbg_state, CREDIT);
    fb_if.cmd_ready = 1'b0;
    beats(16);
    check("t3_second_valid", fb_if.cmd_valid, 1);
    check("t3_second_addr", fb_if.cmd_addr, 32'h0000_2040);
    fb_if.cmd_ready = 1'b1;
    beat_in = 1'b1;           // beat coincides with the handshake: net +15
    tick();
    beat_in = 1'b0;
    check("t3_frame_done", frame_done, 1);
    check("t3_valid_low", fb_if.cmd_valid, 0);
    beats(15);                // back to zero outstanding
    fifo_free = 10'd16;
    set_cfg(32'h0000_3000, 16'h0, 12'd1, 8'd1);
    push(32'h0000_3000, 1);
    start_frame();
    take_cmds(1, 50);
    beats(20);                // last 4 find nothing outstanding
    set_cfg(32'h0000_4000, 16'h0, 12'd1, 8'd1);
    push(32'h0000_4000, 1);
    start_frame();
    take_cmds(1, 50);

    // Backpressure: offer held steady
    do_reset();
    set_cfg(32'h0000_5000, 16'h0, 12'd1, 8'd1);
    fifo_free = 10'd512;
    start_frame();
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", fb_if.cmd_valid, 1);
      check("t4_hold_addr", fb_if.cmd_addr, 32'h0000_5000);
      tick();
    end
    fb_if.cmd_ready = 1'b1;
    push(32'h0000_5000, 1);
    take_cmds(1, 10);

    // Overrun while busy, config changes mid-frame, set-vs-clear priority
    do_reset();
    set_cfg(32'h0000_6000, 16'h0100, 12'd2, 8'd2);
    fifo_free = 10'd512;
    fb_if.cmd_ready = 1'b1;
    push(32'h0000_6000, 0); push(32'h0000_6040, 0);
    push(32'h0000_6100, 0); push(32'h0000_6140, 1);
    start_frame();
    take_cmds(1, 20);
    cfg_base_addr = 32'h0000_7000;
    cfg_stride    = 16'h0999;
    cfg_lines     = 12'd5;
    start_frame();
    check("t5_overrun_set", err_overrun, 1);
    take_cmds(1, 20);
    frame_start = 1'b1;
    err_clr     = 1'b1;
    tick();
    frame_start = 1'b0;
    err_clr     = 1'b0;
    check("t5_set_wins", err_overrun, 1);
    take_cmds(2, 40);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_overrun_clr", err_overrun, 0);

    // Address wrap
    do_reset();
    set_cfg(32'hFFFF_FFC0, 16'h0, 12'd1, 8'd2);
    fb_if.cmd_ready = 1'b1;
    push(32'hFFFF_FFC0, 0); push(32'h0000_0000, 1);
    start_frame();
    take_cmds(2, 30);

    // Asynchronous reset during ISSUE
    do_reset();
    set_cfg(32'h0000_8000, 16'h0, 12'd1, 8'd1);
    start_frame();
    wait_valid(20);
    ARESETN = 1'b0;
    #1;
    check("t7_valid_async", fb_if.cmd_valid, 0);
    check("t7_busy_async", busy, 0);
    check("t7_state_async", dbg_state, IDLE);
    tick();
    ARESETN = 1'b1;
    tick();
    fb_if.cmd_ready = 1'b1;
    push(32'h0000_8000, 1);
    start_frame();
    take_cmds(1, 20);

    // Empty frames and disabled start
    do_reset();
    set_cfg(32'h0000_B000, 16'h0, 12'd0, 8'd3);
    start_frame();
    check("t8_fd_lines0", frame_done, 1);
    check("t8_state_lines0", dbg_state, IDLE);
    check("t8_busy_lines0", busy, 0);
    check("t8_valid_lines0", fb_if.cmd_valid, 0);
    tick();
    check("t8_fd_clear", frame_done, 0);
    set_cfg(32'h0000_B000, 16'h0, 12'd2, 8'd0);
    start_frame();
    check("t8_fd_bursts0", frame_done, 1);
    set_cfg(32'h0000_B000, 16'h0, 12'd2, 8'd2);
    cfg_enable = 1'b0;
    start_frame();
    check("t8_dis_busy", busy, 0);
    check("t8_dis_state", dbg_state, IDLE);

    // Abort in CREDIT
    do_reset();
    fifo_free = 10'd0;
    set_cfg(32'h0000_9000, 16'h0, 12'd1, 8'd1);
    start_frame();
    check("t9_state_credit", dbg_state, CREDIT);
    cfg_enable = 1'b0;
    tick();
    check("t9_abort_state", dbg_state, IDLE);
    check("t9_abort_busy", busy, 0);
    check("t9_abort_fd", frame_done, 0);

    // Abort in ISSUE: offer completes, then idle without frame_done
    fifo_free = 10'd512;
    set_cfg(32'h0000_A000, 16'h0, 12'd1, 8'd2);
    fb_if.cmd_ready = 1'b0;
    start_frame();
    wait_valid(20);
    cfg_enable = 1'b0;
    repeat (3) tick();
    check("t9_pending_valid", fb_if.cmd_valid, 1);
    check("t9_pending_addr", fb_if.cmd_addr, 32'h0000_A000);
    fb_if.cmd_ready = 1'b1;
    tick();
    check("t9_after_valid", fb_if.cmd_valid, 0);
    check("t9_after_state", dbg_state, IDLE);
    check("t9_after_busy", busy, 0);
    check("t9_after_fd", frame_done, 0);
    fb_if.cmd_ready = 1'b0;

    check("exp_q_left", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
